wdt_kick_gate: RTL and testbench
================================

// Module: wdt_kick_gate
// PURPOSE
// - Sits between the CPU write bus and the watchdog timer; produces its clear-watchdog pulse (o_clrwdt -> watchdog i_clrwdt).
// - Kick is accepted only after a two-word key sequence (KEY1 then KEY2), no earlier than i_win_open cycles after the previous kick.
// - Runaway code that writes garbage, wrong order or too early gets no kick; the error is flagged and counted instead.
// PARAMETERS
// - KEY1       16'h5555  first key word
// - KEY2       16'hAAAA  second key word
// - WIN_W      32        width of since-kick counter and i_win_open
// - ARM_TMO    16        max cycles allowed between KEY1 and KEY2 (>=1)
// - ERR_CNT_W  8         width of saturating error counter
// PORTS
// - i_clk        in   1          system clock, all logic on posedge
// - i_rst_n      in   1          asynchronous active-low reset
// - i_wr_en      in   1          CPU write strobe to kick register, 1 cycle per write
// - i_wr_data    in   16         CPU write data
// - i_win_open   in   WIN_W      min cycles since last kick before KEY2 is legal; quasi-static
// - i_err_clr    in   1          clears o_err_flag (not o_err_cnt)
// - o_clrwdt     out  1          1-cycle kick pulse to watchdog
// - o_kick_err   out  1          1-cycle pulse on any sequence/window violation
// - o_err_flag   out  1          sticky error flag
// - o_err_cnt    out  ERR_CNT_W  violations since reset, saturates at all-ones
// - o_win_ok     out  1          since_cnt >= i_win_open (KEY2 would be accepted now)
// - o_state      out  1          0 = IDLE, 1 = ARMED
// BEHAVIOUR
// - Reset (async, i_rst_n=0): state IDLE; since_cnt, arm_cnt, o_err_cnt = 0; o_clrwdt, o_kick_err, o_err_flag = 0.
//   - o_win_ok after reset is combinational: 1 iff i_win_open==0.
// - since_cnt: increments every cycle, saturates at 2^WIN_W-1; cleared to 0 on the edge a kick is accepted.
// - IDLE:
//   - write KEY1 -> ARMED, arm_cnt=0
//   - any other write -> violation, stay IDLE
//   - no write -> stay IDLE
// - ARMED: arm_cnt increments each cycle without a write.
//   - write KEY2 with since_cnt >= i_win_open -> accept; o_clrwdt=1 next cycle; -> IDLE
//   - write KEY2 with since_cnt < i_win_open -> violation (early kick), -> IDLE
//   - write KEY1 or other data -> violation, -> IDLE
//   - arm_cnt reaches ARM_TMO-1 with no write -> violation (timeout), -> IDLE
//   - write and timeout in same cycle: the write decides; timeout ignored.
// - Latency: write sampled at edge N; o_clrwdt / o_kick_err high during cycle N+1 only; state updated at edge N.
// - Violation: o_kick_err pulse, o_err_flag<=1, o_err_cnt+1 (saturating), no kick.
// - i_err_clr and a violation on the same edge: violation wins (flag stays 1).
// - Back-to-back writes every cycle are legal; each is evaluated against the state updated by the previous one.
// - o_clrwdt and o_kick_err are never high in the same cycle.
// - Comparison since_cnt >= i_win_open is unsigned, full WIN_W width.
// - Reset asserted mid-sequence (ARMED) aborts silently: no kick, no error.
// STRUCTURE
// - Package wdt_pkg:
//   - state enum {ST_IDLE, ST_ARMED}
//   - default key constants WDT_KEY1 / WDT_KEY2
//   - shared with the watchdog-timer testbench
// - One sub-module, wdt_sat_counter:
//   - params W; inputs clk, rst_n, inc, clr; output q (saturating)
//   - instanced for since_cnt, arm_cnt and o_err_cnt
// - FSM, decode and output registers live in wdt_kick_gate.
// TESTING
// - i_win_open=10; after reset wait 20 cycles, write 5555 then AAAA -> o_clrwdt pulse 1 cycle after AAAA write, o_err_cnt=0.
// - i_win_open=100; kick accepted at t0, then 5555/AAAA 30 cycles later -> no o_clrwdt, o_kick_err pulse, o_err_flag=1, o_err_cnt=1.
// - Write AAAA in IDLE, then 1234 in IDLE -> two o_kick_err pulses, o_err_cnt=2, state stays IDLE.
// - ARM_TMO=16: write 5555, idle 16 cycles -> o_kick_err on timeout; subsequent AAAA gives another error (cnt=2).
// - ERR_CNT_W=2: five violations -> o_err_cnt saturates at 3; i_err_clr in same cycle as 5th violation -> o_err_flag stays 1.
// - Write 5555, pull i_rst_n low mid-ARMED -> all outputs 0 immediately; AAAA after release -> violation, no kick.

Source files
------------

// File: rtl/wdt_pkg.sv
// Shared watchdog kick-gate types and key constants.
package wdt_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } wdt_state_e;

    localparam int unsigned WDT_DATA_W = 16;
    localparam logic [WDT_DATA_W-1:0] WDT_KEY1 = 16'h5555;
    localparam logic [WDT_DATA_W-1:0] WDT_KEY2 = 16'hAAAA;

endpackage

// File: rtl/wdt_sat_counter.sv
// Saturating up-counter with synchronous clear (clear has priority over increment).
module wdt_sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/wdt_kick_gate.sv
// Key-sequence and window gate in front of the watchdog clear input.
// Violations are flagged and counted instead of producing a kick.
module wdt_kick_gate
    import wdt_pkg::*;
#(
    parameter logic [WDT_DATA_W-1:0] KEY1      = WDT_KEY1,
    parameter logic [WDT_DATA_W-1:0] KEY2      = WDT_KEY2,
    parameter int unsigned           WIN_W     = 32,
    parameter int unsigned           ARM_TMO   = 16,
    parameter int unsigned           ERR_CNT_W = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr_en,
    input  logic [WDT_DATA_W-1:0] i_wr_data,
    input  logic [WIN_W-1:0]      i_win_open,
    input  logic                  i_err_clr,
    output logic                  o_clrwdt,
    output logic                  o_kick_err,
    output logic                  o_err_flag,
    output logic [ERR_CNT_W-1:0]  o_err_cnt,
    output logic                  o_win_ok,
    output logic                  o_state
);

    localparam int unsigned     ARM_W    = (ARM_TMO > 1) ? $clog2(ARM_TMO) : 1;
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_TMO - 1);

    wdt_state_e       state_q, state_d;
    logic [WIN_W-1:0] since_cnt;
    logic [ARM_W-1:0] arm_cnt;
    logic             kick_c, viol_c;
    logic             arm_inc_c;
    logic             clrwdt_q, kick_err_q, err_flag_q, err_flag_d;

    assign o_win_ok = (since_cnt >= i_win_open);

    // Next-state, kick/violation decode and error-flag update.
    always_comb begin
        state_d    = state_q;
        kick_c     = 1'b0;
        viol_c     = 1'b0;
        err_flag_d = err_flag_q;
        case (state_q)
            ST_IDLE: begin
                if (i_wr_en) begin
                    if (i_wr_data == KEY1) begin
                        state_d = ST_ARMED;
                    end else begin
                        viol_c = 1'b1;
                    end
                end
            end
            ST_ARMED: begin
                if (i_wr_en) begin
                    state_d = ST_IDLE;
                    if ((i_wr_data == KEY2) && o_win_ok) begin
                        kick_c = 1'b1;
                    end else begin
                        viol_c = 1'b1;
                    end
                end else if (arm_cnt == ARM_LAST) begin
                    state_d = ST_IDLE;
                    viol_c  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (viol_c) begin
            err_flag_d = 1'b1;
        end else if (i_err_clr) begin
            err_flag_d = 1'b0;
        end
    end

    // arm_cnt only runs while the sequence stays armed; any exit or re-arm zeroes it.
    assign arm_inc_c = (state_q == ST_ARMED) && (state_d == ST_ARMED);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            clrwdt_q   <= 1'b0;
            kick_err_q <= 1'b0;
            err_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clrwdt_q   <= kick_c;
            kick_err_q <= viol_c;
            err_flag_q <= err_flag_d;
        end
    end

    wdt_sat_counter #(.W(WIN_W)) u_since_cnt (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .inc   (1'b1),
        .clr   (kick_c),
        .q     (since_cnt)
    );

    wdt_sat_counter #(.W(ARM_W)) u_arm_cnt (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .inc   (arm_inc_c),
        .clr   (!arm_inc_c),
        .q     (arm_cnt)
    );

    wdt_sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .inc   (viol_c),
        .clr   (1'b0),
        .q     (o_err_cnt)
    );

    assign o_clrwdt   = clrwdt_q;
    assign o_kick_err = kick_err_q;
    assign o_err_flag = err_flag_q;
    assign o_state    = (state_q == ST_ARMED);

endmodule

// File: tb/tb_wdt_kick_gate.sv
// Randomised and directed bench for wdt_kick_gate against a cycle-count reference model.
module tb_wdt_kick_gate;
    import wdt_pkg::*;

    localparam int unsigned WIN_W   = 32;
    localparam int unsigned ARM_TMO = 16;
    localparam int unsigned ERR_W   = 2;
    localparam int          ERR_MAX = (1 << ERR_W) - 1;
    localparam longint      SINCE_MAX = 64'h0000_0000_FFFF_FFFF;

    logic             clk;
    logic             i_rst_n;
    logic             i_wr_en;
    logic [15:0]      i_wr_data;
    logic [WIN_W-1:0] i_win_open;
    logic             i_err_clr;
    logic             o_clrwdt, o_kick_err, o_err_flag, o_win_ok, o_state;
    logic [ERR_W-1:0] o_err_cnt;

    wdt_kick_gate #(
        .WIN_W     (WIN_W),
        .ARM_TMO   (ARM_TMO),
        .ERR_CNT_W (ERR_W)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (i_rst_n),
        .i_wr_en    (i_wr_en),
        .i_wr_data  (i_wr_data),
        .i_win_open (i_win_open),
        .i_err_clr  (i_err_clr),
        .o_clrwdt   (o_clrwdt),
        .o_kick_err (o_kick_err),
        .o_err_flag (o_err_flag),
        .o_err_cnt  (o_err_cnt),
        .o_win_ok   (o_win_ok),
        .o_state    (o_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // {clrwdt, kick_err, err_flag, err_cnt[1:0], win_ok, state}
    wire  [6:0] obs_w = {o_clrwdt, o_kick_err, o_err_flag, o_err_cnt, o_win_ok, o_state};
    logic [6:0] exp_v;

    // Reference model: cycles since last kick, idle cycles since arming, error tally
    bit     m_armed;
    int     m_idle;
    longint m_since;
    int     m_errs;
    bit     m_flag;

    task automatic model_reset();
        m_armed = 0;
        m_idle  = 0;
        m_since = 0;
        m_errs  = 0;
        m_flag  = 0;
        exp_v   = {4'b0000, ERR_W'(0), 1'b0} | {6'b0, 1'b0};
        exp_v   = {1'b0, 1'b0, 1'b0, ERR_W'(0), (i_win_open == '0), 1'b0};
    endtask

    task automatic reset_dut();
        i_rst_n   = 1'b0;
        i_wr_en   = 1'b0;
        i_wr_data = '0;
        i_err_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        i_rst_n = 1'b1;
        model_reset();
    endtask

    // Drive one cycle of inputs, advance the model across the edge, sample #1 after it.
    task automatic step(input logic wr, input logic [15:0] d, input logic clr);
        bit viol, kick;
        i_wr_en   = wr;
        i_wr_data = d;
        i_err_clr = clr;
        viol = 0;
        kick = 0;
        if (m_armed) begin
            if (wr) begin
                m_armed = 0;
                if (d == WDT_KEY2 && m_since >= longint'(i_win_open)) kick = 1;
                else viol = 1;
            end else begin
                m_idle++;
                if (m_idle == ARM_TMO) begin
                    viol    = 1;
                    m_armed = 0;
                end
            end
        end else if (wr) begin
            if (d == WDT_KEY1) begin
                m_armed = 1;
                m_idle  = 0;
            end else begin
                viol = 1;
            end
        end
        if (kick) m_since = 0;
        else if (m_since < SINCE_MAX) m_since++;
        if (viol) begin
            m_flag = 1;
            if (m_errs < ERR_MAX) m_errs++;
        end else if (clr) begin
            m_flag = 0;
        end
        exp_v = {kick, viol, m_flag, ERR_W'(m_errs), (m_since >= longint'(i_win_open)), m_armed};
        @(posedge clk);
        #1;
        i_wr_en   = 1'b0;
        i_err_clr = 1'b0;
    endtask

    task automatic test_reset();
        i_win_open = '0;
        reset_dut();
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (obs_w !== 7'b0000010) begin
            errors++;
            $display("FAIL reset_win0: got %b want %b", obs_w, 7'b0000010);
        end
        i_win_open = 32'd5;
        #1;
        checks++;
        if (obs_w !== 7'b0000000) begin
            errors++;
            $display("FAIL reset_win5: got %b want %b", obs_w, 7'b0000000);
        end
        @(negedge clk);
        i_rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_basic_kick();
        i_win_open = 32'd10;
        reset_dut();
        repeat (20) step(1'b0, 16'h0, 1'b0);
        step(1'b1, WDT_KEY1, 1'b0);
        checks++;
        if (obs_w !== exp_v) begin
            errors++;
            $display("FAIL basic_key1: got %b want %b", obs_w, exp_v);
        end
        step(1'b1, WDT_KEY2, 1'b0);
        checks++;
        if (o_clrwdt !== 1'b1 || o_kick_err !== 1'b0 || o_err_cnt !== 2'd0) begin
            errors++;
            $display("FAIL basic_kick: got clr=%b err=%b cnt=%0d want 1 0 0", o_clrwdt, o_kick_err, o_err_cnt);
        end
        step(1'b0, 16'h0, 1'b0);
        checks++;
        if (obs_w !== exp_v || o_clrwdt !== 1'b0 || o_win_ok !== 1'b0) begin
            errors++;
            $display("FAIL basic_after: got %b want %b", obs_w, exp_v);
        end
    endtask

    task automatic test_early_kick();
        i_win_open = 32'd100;
        reset_dut();
        repeat (105) step(1'b0, 16'h0, 1'b0);
        step(1'b1, WDT_KEY1, 1'b0);
        step(1'b1, WDT_KEY2, 1'b0);
        checks++;
        if (o_clrwdt !== 1'b1) begin
            errors++;
            $display("FAIL early_t0_kick: got %b want 1", o_clrwdt);
        end
        repeat (28) step(1'b0, 16'h0, 1'b0);
        step(1'b1, WDT_KEY1, 1'b0);
        step(1'b1, WDT_KEY2, 1'b0);
        checks++;
        if (o_clrwdt !== 1'b0 || o_kick_err !== 1'b1 || o_err_flag !== 1'b1 || o_err_cnt !== 2'd1) begin
            errors++;
            $display("FAIL early_kick: got clr=%b err=%b flag=%b cnt=%0d want 0 1 1 1",
                     o_clrwdt, o_kick_err, o_err_flag, o_err_cnt);
        end
        checks++;
        if (obs_w !== exp_v) begin
            errors++;
            $display("FAIL early_model: got %b want %b", obs_w, exp_v);
        end
    endtask

    task automatic test_bad_idle();
        i_win_open = 32'd0;
        reset_dut();
        step(1'b1, WDT_KEY2, 1'b0);
        checks++;
        if (o_kick_err !== 1'b1 || o_state !== 1'b0) begin
            errors++;
            $display("FAIL idle_key2: got err=%b st=%b want 1 0", o_kick_err, o_state);
        end
        step(1'b1, 16'h1234, 1'b0);
        checks++;
        if (o_kick_err !== 1'b1 || o_err_cnt !== 2'd2 || o_state !== 1'b0 || obs_w !== exp_v) begin
            errors++;
            $display("FAIL idle_garbage: got %b want %b", obs_w, exp_v);
        end
    endtask

    task automatic test_timeout();
        i_win_open = 32'd0;
        reset_dut();
        step(1'b1, WDT_KEY1, 1'b0);
        for (int i = 1; i < ARM_TMO; i++) begin
            step(1'b0, 16'h0, 1'b0);
            checks++;
            if (obs_w !== exp_v || o_state !== 1'b1) begin
                errors++;
                $display("FAIL tmo_wait%0d: got %b want %b", i, obs_w, exp_v);
            end
        end
        step(1'b0, 16'h0, 1'b0);
        checks++;
        if (o_kick_err !== 1'b1 || o_state !== 1'b0 || o_err_cnt !== 2'd1) begin
            errors++;
            $display("FAIL tmo_fire: got err=%b st=%b cnt=%0d want 1 0 1", o_kick_err, o_state, o_err_cnt);
        end
        step(1'b1, WDT_KEY2, 1'b0);
        checks++;
        if (o_kick_err !== 1'b1 || o_clrwdt !== 1'b0 || o_err_cnt !== 2'd2) begin
            errors++;
            $display("FAIL tmo_late_key2: got err=%b clr=%b cnt=%0d want 1 0 2", o_kick_err, o_clrwdt, o_err_cnt);
        end
    endtask

    task automatic test_saturate();
        i_win_open = 32'd0;
        reset_dut();
        for (int i = 0; i < 4; i++) step(1'b1, 16'h0F0F, 1'b0);
        step(1'b1, 16'h0F0F, 1'b1);
        checks++;
        if (o_err_cnt !== 2'd3 || o_err_flag !== 1'b1 || obs_w !== exp_v) begin
            errors++;
            $display("FAIL sat_5th: got cnt=%0d flag=%b want 3 1", o_err_cnt, o_err_flag);
        end
        step(1'b0, 16'h0, 1'b1);
        checks++;
        if (o_err_cnt !== 2'd3 || o_err_flag !== 1'b0) begin
            errors++;
            $display("FAIL sat_clr: got cnt=%0d flag=%b want 3 0", o_err_cnt, o_err_flag);
        end
    endtask

    task automatic test_reset_mid_armed();
        i_win_open = 32'd10;
        reset_dut();
        step(1'b1, WDT_KEY1, 1'b0);
        checks++;
        if (o_state !== 1'b1) begin
            errors++;
            $display("FAIL mid_armed: got st=%b want 1", o_state);
        end
        #1 i_rst_n = 1'b0;
        #1;
        checks++;
        if (obs_w !== 7'b0000000) begin
            errors++;
            $display("FAIL mid_rst_outputs: got %b want %b", obs_w, 7'b0000000);
        end
        @(negedge clk);
        i_rst_n = 1'b1;
        model_reset();
        step(1'b1, WDT_KEY2, 1'b0);
        checks++;
        if (o_clrwdt !== 1'b0 || o_kick_err !== 1'b1 || o_err_cnt !== 2'd1) begin
            errors++;
            $display("FAIL mid_rst_key2: got clr=%b err=%b cnt=%0d want 0 1 1", o_clrwdt, o_kick_err, o_err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int wr_pct;
        int r;
        logic        wr;
        logic [15:0] d;
        i_win_open = 32'($urandom_range(0, 24));
        reset_dut();
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) wr_pct = (i % 500 == 0) ? 60 : 4;
            if (i % 700 == 350) begin
                reset_dut();
            end
            wr = ($urandom_range(0, 99) < wr_pct);
            r  = $urandom_range(0, 9);
            d  = (r < 4) ? WDT_KEY1 : (r < 8) ? WDT_KEY2 : 16'($urandom);
            step(wr, d, ($urandom_range(0, 15) == 0));
            checks++;
            if (obs_w !== exp_v || (o_clrwdt && o_kick_err)) begin
                errors++;
                $display("FAIL rand_step%0d: got %b want %b", i, obs_w, exp_v);
            end
        end
    endtask

    initial begin
        i_rst_n    = 1'b0;
        i_wr_en    = 1'b0;
        i_wr_data  = '0;
        i_win_open = '0;
        i_err_clr  = 1'b0;
        test_reset();
        test_basic_kick();
        test_early_kick();
        test_bad_idle();
        test_timeout();
        test_saturate();
        test_reset_mid_armed();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
